// File: rtl/ram_arb_dp.sv
// ram_arb_dp: single-array program/data RAM shared by a read-only fetch
// port (A) and a read/write data port (B), one access per cycle.
// Ports: clk, rst (async, active-high); A: a_req/a_addr -> a_gnt,
// a_rvalid, a_rdata; B: b_req/b_we/b_addr/b_wdata -> b_gnt, b_rvalid,
// b_rdata; busy is high while the post-reset clear is running.
module ram_arb_dp #(
   parameter int RAM_WIDTH      = 22,
   parameter int RAM_DEPTH      = 1024,
   parameter int ADDR_SIZE      = 10,
   parameter int CLEAR_ON_RESET = 1,
   parameter int ARB_MODE       = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 a_req,
   input  logic [ADDR_SIZE-1:0] a_addr,
   output logic                 a_gnt,
   output logic                 a_rvalid,
   output logic [RAM_WIDTH-1:0] a_rdata,
   input  logic                 b_req,
   input  logic                 b_we,
   input  logic [ADDR_SIZE-1:0] b_addr,
   input  logic [RAM_WIDTH-1:0] b_wdata,
   output logic                 b_gnt,
   output logic                 b_rvalid,
   output logic [RAM_WIDTH-1:0] b_rdata,
   output logic                 busy
);

   localparam int IDX_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
   localparam logic [ADDR_SIZE:0] DEPTH_L = (ADDR_SIZE+1)'(RAM_DEPTH);
   localparam logic [ADDR_SIZE-1:0] LAST_A = ADDR_SIZE'(RAM_DEPTH - 1);

   typedef enum logic {
      ST_CLEAR,
      ST_RUN
   } state_t;

   localparam state_t RST_ST = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

   logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

   state_t               state_q, state_d;
   logic [ADDR_SIZE-1:0] clr_addr_q, clr_addr_d;
   logic                 last_b_q, last_b_d;
   logic                 a_rvalid_q, a_rvalid_d;
   logic [RAM_WIDTH-1:0] a_rdata_q, a_rdata_d;
   logic                 b_rvalid_q, b_rvalid_d;
   logic [RAM_WIDTH-1:0] b_rdata_q, b_rdata_d;

   logic                 a_in, b_in;
   logic [IDX_W-1:0]     a_idx, b_idx;
   logic [RAM_WIDTH-1:0] a_mem, b_mem;
   logic                 b_rd;
   logic                 mem_we;
   logic [IDX_W-1:0]     mem_idx;
   logic [RAM_WIDTH-1:0] mem_wd;

   assign a_in  = {1'b0, a_addr} < DEPTH_L;
   assign b_in  = {1'b0, b_addr} < DEPTH_L;
   assign a_idx = a_addr[IDX_W-1:0];
   assign b_idx = b_addr[IDX_W-1:0];
   assign a_mem = mem[a_idx];
   assign b_mem = mem[b_idx];

   // Grant looks only at requests, state and last_b, never at the other
   // port's grant, so there is no combinational loop between requesters.
   always_comb begin
      a_gnt = 1'b0;
      b_gnt = 1'b0;
      if (state_q == ST_RUN) begin
         if (a_req && b_req) begin
            if ((ARB_MODE != 0) || last_b_q) begin
               a_gnt = 1'b1;
            end else begin
               b_gnt = 1'b1;
            end
         end else begin
            a_gnt = a_req;
            b_gnt = b_req;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      last_b_d   = last_b_q;
      b_rd       = b_gnt && !b_we;
      a_rvalid_d = a_gnt;
      b_rvalid_d = b_rd;
      a_rdata_d  = a_rdata_q;
      b_rdata_d  = b_rdata_q;
      mem_we     = 1'b0;
      mem_idx    = b_idx;
      mem_wd     = b_wdata;

      if (a_gnt) begin
         a_rdata_d = a_in ? a_mem : '0;
         last_b_d  = 1'b0;
      end
      if (b_gnt) begin
         last_b_d = 1'b1;
      end
      if (b_rd) begin
         b_rdata_d = b_in ? b_mem : '0;
      end

      case (state_q)
         ST_CLEAR: begin
            mem_we     = 1'b1;
            mem_idx    = clr_addr_q[IDX_W-1:0];
            mem_wd     = '0;
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == LAST_A) begin
               state_d    = ST_RUN;
               clr_addr_d = '0;
            end
         end
         default: begin
            // Out-of-range writes are granted but dropped here.
            mem_we = b_gnt && b_we && b_in;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RST_ST;
         clr_addr_q <= '0;
         last_b_q   <= 1'b1;
         a_rvalid_q <= 1'b0;
         a_rdata_q  <= '0;
         b_rvalid_q <= 1'b0;
         b_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         last_b_q   <= last_b_d;
         a_rvalid_q <= a_rvalid_d;
         a_rdata_q  <= a_rdata_d;
         b_rvalid_q <= b_rvalid_d;
         b_rdata_q  <= b_rdata_d;
      end
   end

   // Storage has no reset; the clear sequencer zeroes it instead.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_idx] <= mem_wd;
      end
   end

   assign a_rvalid = a_rvalid_q;
   assign a_rdata  = a_rdata_q;
   assign b_rvalid = b_rvalid_q;
   assign b_rdata  = b_rdata_q;
   assign busy     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ram_arb_dp.sv
// tb_ram_arb_dp: scoreboard bench for ram_arb_dp (16 words, round-robin
// instance plus a fixed-priority instance).
module tb_ram_arb_dp;

   localparam int W = 22;
   localparam int D = 16;
   localparam int A = 10;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         a_req, a_gnt, a_rvalid;
   logic [A-1:0] a_addr;
   logic [W-1:0] a_rdata;
   logic         b_req, b_we, b_gnt, b_rvalid;
   logic [A-1:0] b_addr;
   logic [W-1:0] b_wdata, b_rdata;
   logic         busy;

   logic         f_a_req, f_a_gnt, f_a_rvalid;
   logic [W-1:0] f_a_rdata;
   logic         f_b_req, f_b_gnt, f_b_rvalid;
   logic [W-1:0] f_b_rdata;
   logic         f_busy;

   always #5 clk = ~clk;

   ram_arb_dp #(
      .RAM_WIDTH(W), .RAM_DEPTH(D), .ADDR_SIZE(A),
      .CLEAR_ON_RESET(1), .ARB_MODE(0)
   ) u_rr (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt),
      .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr),
      .b_wdata(b_wdata), .b_gnt(b_gnt),
      .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .busy(busy)
   );

   ram_arb_dp #(
      .RAM_WIDTH(W), .RAM_DEPTH(D), .ADDR_SIZE(A),
      .CLEAR_ON_RESET(1), .ARB_MODE(1)
   ) u_fp (
      .clk(clk), .rst(rst),
      .a_req(f_a_req), .a_addr('0), .a_gnt(f_a_gnt),
      .a_rvalid(f_a_rvalid), .a_rdata(f_a_rdata),
      .b_req(f_b_req), .b_we(1'b0), .b_addr('0),
      .b_wdata('0), .b_gnt(f_b_gnt),
      .b_rvalid(f_b_rvalid), .b_rdata(f_b_rdata),
      .busy(f_busy)
   );

   typedef struct {
      logic [W-1:0] d;
      int           c;
   } exp_t;

   exp_t         qa[$];
   exp_t         qb[$];
   logic [W-1:0] mdl [D];
   logic [W-1:0] ha = '0;
   logic [W-1:0] hb = '0;
   int           checks = 0;
   int           errors = 0;
   int           cyc_cnt = 0;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic bad(input string nm);
      checks++;
      errors++;
      $display("FAIL %s got event want none", nm);
   endtask

   function automatic logic [W-1:0] rd(input logic [A-1:0] ad);
      logic [3:0] ix;
      ix = ad[3:0];
      return (ad < A'(D)) ? mdl[ix] : '0;
   endfunction

   task automatic clr_mdl();
      for (int i = 0; i < D; i++) mdl[i] = '0;
   endtask

   // Drive one cycle, check grants/busy, and push expected read data.
   task automatic cyc(input logic ar, input logic [A-1:0] aa,
                      input logic br, input logic bw,
                      input logic [A-1:0] ba, input logic [W-1:0] bd,
                      input logic ega, input logic egb,
                      input logic ebusy);
      exp_t e;
      a_req = ar; a_addr = aa;
      b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
      @(negedge clk);
      chk("a_gnt", a_gnt, ega);
      chk("b_gnt", b_gnt, egb);
      chk("busy", busy, ebusy);
      if (ega) begin
         e.d = rd(aa); e.c = cyc_cnt + 1;
         qa.push_back(e);
      end
      if (egb) begin
         if (bw) begin
            if (ba < A'(D)) mdl[ba[3:0]] = bd;
         end else begin
            e.d = rd(ba); e.c = cyc_cnt + 1;
            qb.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(0, '0, 0, 0, '0, '0, 0, 0, 0);
   endtask

   task automatic fcyc(input logic ar, input logic br,
                       input logic ega, input logic egb);
      f_a_req = ar; f_b_req = br;
      @(negedge clk);
      chk("f_a_gnt", f_a_gnt, ega);
      chk("f_b_gnt", f_b_gnt, egb);
      chk("f_busy", f_busy, 1'b0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: rvalid pops the scoreboard; otherwise rdata must hold.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         ha = '0;
         hb = '0;
      end else begin
         if (a_rvalid) begin
            if (qa.size() == 0) bad("a_spurious_rvalid");
            else begin
               e = qa.pop_front();
               chk("a_rdata", a_rdata, e.d);
               chk("a_latency", cyc_cnt, e.c);
               ha = e.d;
            end
         end else chk("a_hold", a_rdata, ha);
         if (b_rvalid) begin
            if (qb.size() == 0) bad("b_spurious_rvalid");
            else begin
               e = qb.pop_front();
               chk("b_rdata", b_rdata, e.d);
               chk("b_latency", cyc_cnt, e.c);
               hb = e.d;
            end
         end else chk("b_hold", b_rdata, hb);
         if (qa.size() > 0 && qa[0].c < cyc_cnt) begin
            bad("a_missing_rvalid");
            void'(qa.pop_front());
         end
         if (qb.size() > 0 && qb[0].c < cyc_cnt) begin
            bad("b_missing_rvalid");
            void'(qb.pop_front());
         end
      end
   end

   initial begin
      a_req = 0; a_addr = '0;
      b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
      f_a_req = 0; f_b_req = 0;
      clr_mdl();
      #1 rst = 1;
      a_req = 1; b_req = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_a_gnt", a_gnt, 1'b0);
      chk("rst_b_gnt", b_gnt, 1'b0);
      chk("rst_busy", busy, 1'b1);
      chk("rst_a_rvalid", a_rvalid, 1'b0);
      chk("rst_b_rvalid", b_rvalid, 1'b0);
      chk("rst_a_rdata", a_rdata, '0);
      chk("rst_b_rdata", b_rdata, '0);
      @(posedge clk);
      #1 rst = 0;

      // Clear: 16 busy cycles, no grant despite a_req.
      for (int i = 0; i < D; i++) cyc(1, '0, 0, 0, '0, '0, 0, 0, 1);
      for (int i = 0; i < D; i++) cyc(1, A'(i), 0, 0, '0, '0, 1, 0, 0);
      idle();

      // B write then read back.
      cyc(0, '0, 1, 1, 10'd5, 22'h155AA, 0, 1, 0);
      cyc(0, '0, 1, 0, 10'd5, '0, 0, 1, 0);
      idle();

      // Round-robin contention: A first (B was granted last).
      for (int i = 0; i < 6; i++)
         cyc(1, 10'd3, 1, 0, 10'd5, '0, (i % 2) == 0, (i % 2) == 1, 0);
      idle();

      // Out-of-range write must not alias onto address 4.
      cyc(0, '0, 1, 1, 10'd4, 22'h0ABCD, 0, 1, 0);
      cyc(0, '0, 1, 1, 10'd20, 22'h3FFFFF, 0, 1, 0);
      cyc(1, 10'd20, 0, 0, '0, '0, 1, 0, 0);
      cyc(1, 10'd4, 0, 0, '0, '0, 1, 0, 0);
      cyc(0, '0, 1, 0, 10'd20, '0, 0, 1, 0);
      cyc(0, '0, 1, 1, 10'd12, 22'h2A5A5, 0, 1, 0);
      cyc(1, 10'd12, 0, 0, '0, '0, 1, 0, 0);
      idle();

      // Fixed priority instance.
      for (int i = 0; i < 4; i++) fcyc(1, 1, 1, 0);
      fcyc(0, 1, 0, 1);
      fcyc(0, 0, 0, 0);

      // Reset mid-clear restarts the sequence from address 0.
      rst = 1;
      clr_mdl();
      cyc(1, '0, 1, 0, '0, '0, 0, 0, 1);
      rst = 0;
      for (int i = 0; i < 7; i++) cyc(1, '0, 0, 0, '0, '0, 0, 0, 1);
      rst = 1;
      for (int i = 0; i < 2; i++) cyc(1, '0, 1, 0, '0, '0, 0, 0, 1);
      rst = 0;
      for (int i = 0; i < D; i++) cyc(1, '0, 0, 0, '0, '0, 0, 0, 1);
      // last_b is back at 1, so A wins the first contention.
      cyc(1, 10'd12, 1, 0, 10'd5, '0, 1, 0, 0);
      cyc(0, '0, 1, 0, 10'd5, '0, 0, 1, 0);
      idle();
      idle();

      chk("a_queue_left", qa.size(), 0);
      chk("b_queue_left", qb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
